// File: rtl/test_control_pkg.sv
// Shared types for the test pulse sequencer: FSM states and counter width.
package test_control_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_ARM  = 2'd3
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/test_pulse_seq.sv
// Test pulse sequencer: programmable period/width/count pulse train with abort.
// Define TEST_PULSE_TRIG_EN to add trig_in/mode for externally armed pulses.
module test_pulse_seq
   import test_control_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] count,
`ifdef TEST_PULSE_TRIG_EN
   input  logic             trig_in,
   input  logic             mode,
`endif
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] per_q, wid_q, cnt_q, rem_q, tmr_q;
   logic [CNT_W-1:0] rem_nxt, tmr_nxt, pcnt_nxt, low_len;
   logic             load, done_nxt, more;
   logic             arm_start, arm_run, trig_edge;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? v : v - ONE;
   endfunction

`ifdef TEST_PULSE_TRIG_EN
   logic mode_q, trig_s, trig_d;

   sync_2ff u_trig_sync (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .d     (trig_in),
      .q     (trig_s)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         trig_d <= 1'b0;
         mode_q <= 1'b0;
      end else begin
         trig_d <= trig_s;
         if (load) mode_q <= mode;
      end
   end

   assign arm_start = mode;
   assign arm_run   = mode_q;
   assign trig_edge = trig_s & ~trig_d;
`else
   assign arm_start = 1'b0;
   assign arm_run   = 1'b0;
   assign trig_edge = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr_q;
      rem_nxt   = rem_q;
      pcnt_nxt  = pulse_cnt;
      done_nxt  = 1'b0;
      load      = 1'b0;
      low_len   = (per_q > wid_q) ? per_q - wid_q : ONE;
      more      = (cnt_q == '0) || (rem_q != '0);
      unique case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               load     = 1'b1;
               pcnt_nxt = '0;
               rem_nxt  = count;
               if (width == '0) begin
                  done_nxt = 1'b1;
               end else if (arm_start) begin
                  state_nxt = ST_ARM;
               end else begin
                  state_nxt = ST_HIGH;
                  tmr_nxt   = width - ONE;
                  rem_nxt   = sat_dec(count);
                  pcnt_nxt  = ONE;
               end
            end
         end
         ST_ARM: begin
            if (trig_edge) begin
               state_nxt = ST_HIGH;
               tmr_nxt   = wid_q - ONE;
               rem_nxt   = sat_dec(rem_q);
               pcnt_nxt  = sat_inc(pulse_cnt);
            end
         end
         ST_HIGH: begin
            if (tmr_q == '0) begin
               state_nxt = ST_LOW;
               tmr_nxt   = low_len - ONE;
            end else begin
               tmr_nxt = tmr_q - ONE;
            end
         end
         ST_LOW: begin
            if (tmr_q != '0) begin
               tmr_nxt = tmr_q - ONE;
            end else if (!more) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end else if (arm_run) begin
               state_nxt = ST_ARM;
            end else begin
               state_nxt = ST_HIGH;
               tmr_nxt   = wid_q - ONE;
               rem_nxt   = sat_dec(rem_q);
               pcnt_nxt  = sat_inc(pulse_cnt);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // abort overrides every transition out of a running state
      if (abort && state != ST_IDLE) begin
         state_nxt = ST_IDLE;
         done_nxt  = 1'b0;
         tmr_nxt   = tmr_q;
         rem_nxt   = rem_q;
         pcnt_nxt  = pulse_cnt;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= ST_IDLE;
         per_q     <= '0;
         wid_q     <= '0;
         cnt_q     <= '0;
         rem_q     <= '0;
         tmr_q     <= '0;
         pulse_cnt <= '0;
         pulse_out <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         tmr_q     <= tmr_nxt;
         rem_q     <= rem_nxt;
         pulse_cnt <= pcnt_nxt;
         pulse_out <= (state_nxt == ST_HIGH);
         done      <= done_nxt;
         if (load) begin
            per_q <= period;
            wid_q <= width;
            cnt_q <= count;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_test_pulse_seq.sv
// Self-checking bench for test_pulse_seq (default build, free-running mode).
module tb_test_pulse_seq;

   localparam int CNT_W = 32;

   typedef struct {
      int p;
      int w;
      int c;
      int exp_done_k;
      int exp_high;
      int exp_cnt;
   } vec_t;

   logic             tb_ACLK = 1'b0;
   logic             ARESETN;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] count;
   logic             pulse_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulse_cnt;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[6];

   always #5 tb_ACLK = ~tb_ACLK;

   test_pulse_seq #(.CNT_W(CNT_W)) dut (
      .ACLK      (tb_ACLK),
      .ARESETN   (ARESETN),
      .start     (start),
      .abort     (abort),
      .period    (period),
      .width     (width),
      .count     (count),
      .pulse_out (pulse_out),
      .busy      (busy),
      .done      (done),
      .pulse_cnt (pulse_cnt)
   );

   task automatic step();
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic pl, input logic bs,
                                      input logic dn, input int cn);
      return {29'd0, pl, bs, dn, 32'(cn)};
   endfunction

   function automatic logic [63:0] obs();
      return {29'd0, pulse_out, busy, done, pulse_cnt};
   endfunction

   // Expected outputs k cycles after the edge that accepted start.
   function automatic logic [63:0] model(input int p, input int w,
                                         input int c, input int k);
      int len, tot, pos;
      if (w == 0) return mk(1'b0, 1'b0, (k == 1), 0);
      len = w + ((p > w) ? p - w : 1);
      tot = (c == 0) ? 1_000_000_000 : c * len;
      if (k <= tot) begin
         pos = (k - 1) % len;
         return mk((pos < w), 1'b1, 1'b0, (k - 1) / len + 1);
      end
      if (k == tot + 1) return mk(1'b0, 1'b0, 1'b1, c);
      return mk(1'b0, 1'b0, 1'b0, c);
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int highs = 0;
      int dk    = 0;
      period = v.p;
      width  = v.w;
      count  = v.c;
      start  = 1'b1;
      step();
      start  = 1'b0;
      period = $urandom;
      width  = $urandom;
      count  = $urandom;
      for (int k = 1; k <= 200; k++) begin
         if (pulse_out) highs++;
         if (done) begin
            dk = k;
            break;
         end
         step();
      end
      chk($sformatf("vec%0d_done_cycle", idx), dk, v.exp_done_k);
      chk($sformatf("vec%0d_high_cycles", idx), highs, v.exp_high);
      chk($sformatf("vec%0d_pulse_cnt", idx), pulse_cnt, v.exp_cnt);
      chk($sformatf("vec%0d_busy_at_done", idx), busy, 0);
      step();
      chk($sformatf("vec%0d_done_width", idx), done, 0);
   endtask

   task automatic run_rand(input int p, input int w, input int c,
                           input int ab, input int idx);
      int len, tot, lim;
      logic [63:0] e, at_ab, held;
      len  = w + ((p > w) ? p - w : 1);
      tot  = (w == 0) ? 0 : ((c == 0) ? 1_000_000_000 : c * len);
      lim  = (ab > 0) ? ab + 3 : tot + 3;
      at_ab = model(p, w, c, ab);
      held  = mk(1'b0, 1'b0, 1'b0, int'(at_ab[31:0]));
      period = p;
      width  = w;
      count  = c;
      abort  = 1'b0;
      start  = 1'b1;
      step();
      for (int k = 1; k <= lim; k++) begin
         e = (ab > 0 && k > ab) ? held : model(p, w, c, k);
         chk($sformatf("rand%0d_p%0d_w%0d_c%0d_k%0d", idx, p, w, c, k),
             obs(), e);
         period = $urandom;
         width  = $urandom;
         count  = $urandom;
         start  = (k <= tot && (ab == 0 || k <= ab)) ? 1'($urandom) : 1'b0;
         abort  = (k == ab);
         step();
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int p, w, c, ab, len;
      vecs[0] = '{p: 10, w: 3, c: 4, exp_done_k: 41, exp_high: 12, exp_cnt: 4};
      vecs[1] = '{p: 5,  w: 0, c: 3, exp_done_k: 1,  exp_high: 0,  exp_cnt: 0};
      vecs[2] = '{p: 2,  w: 5, c: 2, exp_done_k: 13, exp_high: 10, exp_cnt: 2};
      vecs[3] = '{p: 4,  w: 4, c: 3, exp_done_k: 16, exp_high: 12, exp_cnt: 3};
      vecs[4] = '{p: 1,  w: 1, c: 1, exp_done_k: 3,  exp_high: 1,  exp_cnt: 1};
      vecs[5] = '{p: 6,  w: 1, c: 2, exp_done_k: 13, exp_high: 2,  exp_cnt: 2};

      ARESETN = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      period  = '0;
      width   = '0;
      count   = '0;
      #2;
      chk("reset_state", obs(), mk(1'b0, 1'b0, 1'b0, 0));
      step();
      ARESETN = 1'b1;
      step();
      step();
      chk("idle_after_reset", obs(), mk(1'b0, 1'b0, 1'b0, 0));

      foreach (vecs[i]) run_vec(vecs[i], i);

      // start and abort together while idle: start discarded
      period = 8;
      width  = 2;
      count  = 3;
      start  = 1'b1;
      abort  = 1'b1;
      step();
      start  = 1'b0;
      abort  = 1'b0;
      chk("start_abort_idle", obs(), mk(1'b0, 1'b0, 1'b0, 2));
      step();
      chk("start_abort_idle_2", obs(), mk(1'b0, 1'b0, 1'b0, 2));

      // continuous run beyond 100 pulses, then abort in HIGH
      period = 8;
      width  = 2;
      count  = 0;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int k = 1; k <= 801; k++) begin
         chk($sformatf("cont_k%0d", k), obs(), model(8, 2, 0, k));
         if (k < 801) step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("cont_abort", obs(), mk(1'b0, 1'b0, 1'b0, 101));
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("cont_after_abort%0d", k), obs(),
             mk(1'b0, 1'b0, 1'b0, 101));
      end

      // start while busy is ignored
      period = 6;
      width  = 2;
      count  = 2;
      start  = 1'b1;
      step();
      start  = 1'b0;
      step();
      period = 3;
      width  = 1;
      count  = 5;
      start  = 1'b1;
      step();
      start  = 1'b0;
      chk("busy_start_k3", obs(), model(6, 2, 2, 3));
      for (int k = 4; k <= 14; k++) begin
         step();
         chk($sformatf("busy_start_k%0d", k), obs(), model(6, 2, 2, k));
      end

      // reset asserted mid-LOW clears everything at once
      period = 10;
      width  = 3;
      count  = 4;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int k = 2; k <= 5; k++) step();
      chk("pre_reset_low", obs(), model(10, 3, 4, 5));
      #2;
      ARESETN = 1'b0;
      #1;
      chk("async_reset", obs(), mk(1'b0, 1'b0, 1'b0, 0));
      step();
      ARESETN = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post_reset_idle%0d", k), obs(),
             mk(1'b0, 1'b0, 1'b0, 0));
      end

      // randomised sequences against the reference model
      for (int i = 0; i < 25; i++) begin
         p   = $urandom_range(1, 12);
         w   = $urandom_range(0, 6);
         c   = $urandom_range(0, 4);
         len = w + ((p > w) ? p - w : 1);
         if (w == 0) ab = 0;
         else if (c == 0) ab = $urandom_range(1, 40);
         else if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, c * len);
         else ab = 0;
         run_rand(p, w, c, ab, i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
